// File: rtl/piso_tx_pkg.sv
// rtl/piso_tx_pkg.sv - shared state encoding and default word width for piso_tx
package piso_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_tx_bit_counter.sv
// rtl/piso_tx_bit_counter.sv - frame bit counter with terminal count at WIDTH-1
module piso_tx_bit_counter #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in/serial-out transmitter, MSB first, one bit per clock
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             last
);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic             load_ready_q;
    logic             sdo_valid_q;
    logic             accept;
    logic             terminal;

    assign accept = (state_q == ST_IDLE) && load_valid;

    // The counter holds at WIDTH-1 on the final bit so it never wraps inside a frame.
    piso_tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   ((state_q == ST_SHIFT) && !terminal),
        .terminal (terminal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            load_ready_q <= 1'b1;
            sdo_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        state_q      <= ST_SHIFT;
                        shreg_q      <= data_in;
                        load_ready_q <= 1'b0;
                        sdo_valid_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                    if (terminal) begin
                        state_q      <= ST_IDLE;
                        load_ready_q <= 1'b1;
                        sdo_valid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // After a full frame the register has shifted to zero, but gate anyway so an idle sdo is always 0.
    assign sdo        = shreg_q[WIDTH-1] & sdo_valid_q;
    assign sdo_valid  = sdo_valid_q;
    assign load_ready = load_ready_q;
    assign last       = (state_q == ST_SHIFT) && terminal;

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - scoreboard bench for piso_tx with directed and random frames
module tb_piso_tx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic             sdo;
    logic             sdo_valid;
    logic             last;

    int compared   = 0;
    int mismatched = 0;

    // Model: bits still to be shown from the current cycle on; queue of {bit, last} expected.
    int         bits_left = 0;
    bit         mon_en    = 1'b0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    piso_tx #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sdo        (sdo),
        .sdo_valid  (sdo_valid),
        .last       (last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance the model to the state after the coming edge.
    task automatic cycle(input logic rst, input logic lv, input logic [WIDTH-1:0] d);
        @(posedge clk);
        #1;
        reset      = rst;
        load_valid = lv;
        data_in    = d;
        @(negedge clk);
        #1;
        if (rst) begin
            bits_left = 0;
            exp_q.delete();
            mon_en = 1'b1;
        end else if (bits_left == 0 && lv) begin
            bits_left = WIDTH;
            for (int k = 0; k < WIDTH; k++) begin
                exp_q.push_back({d[WIDTH-1-k], (k == WIDTH - 1) ? 1'b1 : 1'b0});
            end
        end else if (bits_left > 0) begin
            bits_left--;
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (mon_en) begin
            chk("load_ready", load_ready, bits_left == 0);
            chk("sdo_valid", sdo_valid, bits_left > 0);
            if (sdo_valid === 1'b1) begin
                chk("queue_has_bit", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sdo", sdo, e[1]);
                    chk("last", last, e[0]);
                end
            end else begin
                chk("idle_sdo", sdo, 0);
                chk("idle_last", last, 0);
            end
        end
    end

    initial begin
        // Reset held for two cycles, then quiet idle.
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        repeat (4) cycle(1'b0, 1'b0, '0);

        // Single frame 0xA5.
        cycle(1'b0, 1'b1, 8'hA5);
        repeat (WIDTH + 2) cycle(1'b0, 1'b0, '0);

        // Back-to-back with load_valid held high: 0x80 then 0x01.
        cycle(1'b0, 1'b1, 8'h80);
        repeat (WIDTH) cycle(1'b0, 1'b1, 8'h80);
        repeat (WIDTH) cycle(1'b0, 1'b1, 8'h01);
        cycle(1'b0, 1'b0, '0);
        repeat (WIDTH + 2) cycle(1'b0, 1'b0, '0);

        // Inputs ignored during SHIFT: 0xFF then 0x00 offered the whole frame.
        cycle(1'b0, 1'b1, 8'hFF);
        repeat (WIDTH) cycle(1'b0, 1'b1, 8'h00);
        repeat (WIDTH + 2) cycle(1'b0, 1'b0, '0);

        // Reset during the third bit of 0xF0, then 0x0F.
        cycle(1'b0, 1'b1, 8'hF0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 8'h0F);
        repeat (WIDTH + 2) cycle(1'b0, 1'b0, '0);

        // Reset and load at the same edge.
        cycle(1'b1, 1'b1, 8'h55);
        repeat (3) cycle(1'b0, 1'b0, '0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                  WIDTH'($urandom));
        end

        repeat (WIDTH + 3) cycle(1'b0, 1'b0, '0);
        chk("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
